ibex_pext_mc_adder_ctrl: RTL and testbench
==========================================

Name: ibex_pext_mc_adder_ctrl

Overview:
- Sequencer for the area-reduced Pext configuration. One shared 16-bit SIMD adder lane executes every Zpn add/sub-class op in two passes: low halfword (LO), then high halfword (HI).
- Accepts decoded controls from the Pext helper decode (width32, width8, alu_sub[1:0]) plus operands from EX. Drives per-pass adder operands, sub and carry-in, and assembles the 32-bit result and per-byte carries for the saturation/rounding stage.
- Hands the result back to EX with a valid/ack handshake.

Parameters:
- HoldResult, 1'b1: 1 = result held with valid_o until result_ack_i; 0 = valid_o is a one-cycle pulse and result_ack_i is ignored.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  op request; accepted only when ready_o=1
- kill_i  in  1  abort in-flight op (EX flush)
- width32_i  in  1  32-bit op (carry chains LO->HI)
- width8_i  in  1  byte-SIMD op; ignored if width32_i=1
- alu_sub_i  in  2  bit0 = sub for low halfword, bit1 = sub for high halfword
- operand_a_i  in  32  operand A
- operand_b_i  in  32  operand B
- ready_o  out  1  idle, can accept start_i
- adder_a_o  out  16  adder operand A for the current pass
- adder_b_o  out  16  adder operand B for the current pass
- adder_sub_o  out  1  adder computes a + ~b + cin when 1
- adder_cin_o  out  2  cin per byte of the lane; bit1 used only when width8
- adder_byte_mode_o  out  1  break the carry between lane bytes
- adder_result_i  in  16  adder sum, same cycle
- adder_carry_i  in  2  carry-out of lane byte0 / byte1 (bit1 = lane carry-out)
- valid_o  out  1  result_o / carry_o valid
- result_ack_i  in  1  EX consumed result
- result_o  out  32  assembled result
- carry_o  out  4  carry-out per result byte

Behaviour:
- States: IDLE, LO, HI, DONE. All state, result, carry and control registers are synchronously cleared by rst_i.
- Reset values: state=IDLE, ready_o=1, valid_o=0, result_o=0, carry_o=0, adder_*_o=0.
- IDLE: ready_o=1. On start_i, register operands and controls, then go to LO. start_i is ignored in all other states.
- LO (cycle+1):
  - adder_a_o=A[15:0], adder_b_o=B[15:0], adder_sub_o=alu_sub[0].
  - cin: word/half mode -> adder_cin_o={1'b0, alu_sub[0]}. Byte mode -> {alu_sub[0], alu_sub[0]}, adder_byte_mode_o=1.
  - Capture result[15:0] and carries. Next state: HI.
- HI (cycle+2):
  - adder_a_o=A[31:16], adder_b_o=B[31:16].
  - Word mode: adder_sub_o=alu_sub[0]; adder_cin_o[0]=LO lane carry-out (registered carry_o[1]).
  - Half/byte mode: adder_sub_o=alu_sub[1]; cin formed as in LO using alu_sub[1].
  - Capture result[31:16] and carries. Next state: DONE.
- DONE (cycle+3):
  - valid_o=1, result_o and carry_o stable.
  - HoldResult=1: stay until result_ack_i, then IDLE. Ack in the first DONE cycle -> IDLE next cycle.
  - HoldResult=0: always IDLE next cycle.
- Latency: start accepted at cycle N -> valid_o at N+3. Max throughput is one op per 4 cycles.
- Carry packing:
  - Byte mode: carry_o[i] = carry-out of byte i.
  - Half mode: carry_o[1] and carry_o[3] are the halfword carries; carry_o[0] and carry_o[2] are 0.
  - Word mode: carry_o[3] is the 32-bit carry; all other bits are 0.
- Outside LO/HI, adder_*_o are driven to 0 (no toggling).
- kill_i in LO/HI/DONE -> IDLE next cycle, valid_o=0, captured result discarded. kill_i has priority over result_ack_i. kill_i in IDLE has no effect; a start_i coincident with kill_i in IDLE is still accepted.
- rst_i mid-operation -> IDLE next cycle with all outputs at reset values.

Optional Feature:
- Macro IBEX_PEXT_MC_PERF_CNT_EN.
- Defined: adds output perf_ops_o[31:0], which counts ops reaching DONE that are not killed. It increments once per op, on entry to DONE, saturates at 0xFFFF_FFFF, and is cleared by rst_i.
- Undefined: no port, no counter logic.

Test Plan:
- Word add: A=0x0001_FFFF, B=0x0000_0001, width32=1, sub=00, start@N -> HI cin=1, valid@N+3, result_o=0x0002_0000, carry_o=0x0.
- Word sub: A=0x0000_0000, B=0x0000_0001, sub=11 -> result_o=0xFFFF_FFFF, carry_o=0x0; LO cin=1, HI cin=0.
- Crossed half op: A=0x0005_0003, B=0x0002_0001, sub=01, width32=0 -> result_o=0x0007_0002; adder_sub_o=1 in LO, 0 in HI.
- Byte sub: A=0x1010_1010, B=0x0101_0101, width8=1, sub=11 -> adder_byte_mode_o=1, adder_cin_o=2'b11, result_o=0x0F0F_0F0F, carry_o=0xF.
- Backpressure (HoldResult=1): hold result_ack_i=0 for 5 cycles -> valid_o and result_o stable, ready_o=0, second start_i ignored. Ack -> ready_o=1 next cycle.
- Kill and reset: kill_i during HI -> no valid_o, ready_o=1 next cycle. rst_i during LO -> all outputs at reset values next cycle. A fresh op afterwards completes correctly in 3 cycles.

Source files
------------

// File: rtl/ibex_pext_mc_adder_ctrl.sv
// ---------------------------------------------------------------------------
// ibex_pext_mc_adder_ctrl : two-pass (LO/HI) sequencer for one shared 16-bit
// SIMD adder lane. Optional macro: IBEX_PEXT_MC_PERF_CNT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ibex_pext_mc_adder_ctrl #(
  parameter bit HoldResult = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        kill_i,
  input  logic        width32_i,
  input  logic        width8_i,
  input  logic [1:0]  alu_sub_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  output logic        ready_o,
  output logic [15:0] adder_a_o,
  output logic [15:0] adder_b_o,
  output logic        adder_sub_o,
  output logic [1:0]  adder_cin_o,
  output logic        adder_byte_mode_o,
  input  logic [15:0] adder_result_i,
  input  logic [1:0]  adder_carry_i,
  output logic        valid_o,
  input  logic        result_ack_i,
  output logic [31:0] result_o,
  output logic [3:0]  carry_o
`ifdef IBEX_PEXT_MC_PERF_CNT_EN
  ,
  output logic [31:0] perf_ops_o
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] op_a_q, op_b_q;
  logic        width32_q, byte_q;
  logic [1:0]  sub_q;
  logic [31:0] result_q;
  logic [3:0]  carry_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d           = state_q;
    adder_a_o         = 16'h0000;
    adder_b_o         = 16'h0000;
    adder_sub_o       = 1'b0;
    adder_cin_o       = 2'b00;
    adder_byte_mode_o = 1'b0;
    case (state_q)
      IDLE: if (start_i) state_d = LO;
      LO: begin
        state_d           = kill_i ? IDLE : HI;
        adder_a_o         = op_a_q[15:0];
        adder_b_o         = op_b_q[15:0];
        adder_sub_o       = sub_q[0];
        adder_cin_o       = byte_q ? {2{sub_q[0]}} : {1'b0, sub_q[0]};
        adder_byte_mode_o = byte_q;
      end
      HI: begin
        state_d           = kill_i ? IDLE : DONE;
        adder_a_o         = op_a_q[31:16];
        adder_b_o         = op_b_q[31:16];
        adder_byte_mode_o = byte_q;
        // Word ops chain the LO lane carry-out into the high pass.
        if (width32_q) begin
          adder_sub_o = sub_q[0];
          adder_cin_o = {1'b0, carry_q[1]};
        end else begin
          adder_sub_o = sub_q[1];
          adder_cin_o = byte_q ? {2{sub_q[1]}} : {1'b0, sub_q[1]};
        end
      end
      DONE: if (kill_i || !HoldResult || result_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_a_q    <= 32'h0;
      op_b_q    <= 32'h0;
      width32_q <= 1'b0;
      byte_q    <= 1'b0;
      sub_q     <= 2'b00;
      result_q  <= 32'h0;
      carry_q   <= 4'h0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          op_a_q    <= operand_a_i;
          op_b_q    <= operand_b_i;
          width32_q <= width32_i;
          byte_q    <= width8_i & ~width32_i;
          sub_q     <= alu_sub_i;
          result_q  <= 32'h0;
          carry_q   <= 4'h0;
        end
        LO: if (kill_i) begin
          result_q <= 32'h0;
          carry_q  <= 4'h0;
        end else begin
          result_q[15:0] <= adder_result_i;
          carry_q        <= byte_q ? {2'b00, adder_carry_i}
                                   : {2'b00, adder_carry_i[1], 1'b0};
        end
        HI: if (kill_i) begin
          result_q <= 32'h0;
          carry_q  <= 4'h0;
        end else begin
          result_q[31:16] <= adder_result_i;
          // Word mode drops the intermediate LO carry from the packed result.
          if (width32_q)   carry_q      <= {adder_carry_i[1], 3'b000};
          else if (byte_q) carry_q[3:2] <= adder_carry_i;
          else             carry_q[3:2] <= {adder_carry_i[1], 1'b0};
        end
        DONE: if (kill_i) begin
          result_q <= 32'h0;
          carry_q  <= 4'h0;
        end
        default: ;
      endcase
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign result_o = result_q;
  assign carry_o  = carry_q;

`ifdef IBEX_PEXT_MC_PERF_CNT_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) perf_q <= 32'h0;
    else if (state_q == HI && !kill_i && perf_q != 32'hFFFF_FFFF) perf_q <= perf_q + 32'd1;
  end
  assign perf_ops_o = perf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ibex_pext_mc_adder_ctrl.sv
// Self-checking bench: behavioural adder lane, op-level reference model, directed + random ops.
`default_nettype none

module tb_ibex_pext_mc_adder_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_i, start_i, kill_i, width32_i, width8_i, result_ack_i;
  logic [1:0]  alu_sub_i;
  logic [31:0] operand_a_i, operand_b_i;
  logic        ready_o, adder_sub_o, adder_byte_mode_o, valid_o;
  logic [15:0] adder_a_o, adder_b_o, adder_result_i;
  logic [1:0]  adder_cin_o, adder_carry_i;
  logic [31:0] result_o;
  logic [3:0]  carry_o;
`ifdef IBEX_PEXT_MC_PERF_CNT_EN
  logic [31:0] perf_ops_o;
`endif

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  ibex_pext_mc_adder_ctrl #(.HoldResult(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .kill_i(kill_i),
    .width32_i(width32_i), .width8_i(width8_i), .alu_sub_i(alu_sub_i),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .ready_o(ready_o),
    .adder_a_o(adder_a_o), .adder_b_o(adder_b_o), .adder_sub_o(adder_sub_o),
    .adder_cin_o(adder_cin_o), .adder_byte_mode_o(adder_byte_mode_o),
    .adder_result_i(adder_result_i), .adder_carry_i(adder_carry_i),
    .valid_o(valid_o), .result_ack_i(result_ack_i), .result_o(result_o),
    .carry_o(carry_o)
`ifdef IBEX_PEXT_MC_PERF_CNT_EN
    , .perf_ops_o(perf_ops_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Shared 16-bit lane: a + (sub ? ~b : b) + cin, byte carry optionally broken.
  logic [15:0] lane_b;
  logic [8:0]  lane_lo, lane_hi;
  always_comb begin
    lane_b  = adder_sub_o ? ~adder_b_o : adder_b_o;
    lane_lo = {1'b0, adder_a_o[7:0]} + {1'b0, lane_b[7:0]} + {8'h0, adder_cin_o[0]};
    lane_hi = {1'b0, adder_a_o[15:8]} + {1'b0, lane_b[15:8]}
            + {8'h0, (adder_byte_mode_o ? adder_cin_o[1] : lane_lo[8])};
    adder_result_i = {lane_hi[7:0], lane_lo[7:0]};
    adder_carry_i  = {lane_hi[8], lane_lo[8]};
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Whole-op reference: result in [31:0], packed carries in [35:32].
  function automatic logic [35:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic w32, input logic w8, input logic [1:0] sub);
    logic [31:0] res;
    logic [3:0]  car;
    logic [32:0] s33;
    logic [16:0] s17;
    logic [8:0]  s9;
    logic        sb;
    res = 32'h0;
    car = 4'h0;
    if (w32) begin
      s33 = {1'b0, a} + {1'b0, (sub[0] ? ~b : b)} + {32'h0, sub[0]};
      res = s33[31:0];
      car[3] = s33[32];
    end else if (w8) begin
      for (int i = 0; i < 4; i++) begin
        sb = sub[i/2];
        s9 = {1'b0, a[8*i +: 8]} + {1'b0, (sb ? ~b[8*i +: 8] : b[8*i +: 8])} + {8'h0, sb};
        res[8*i +: 8] = s9[7:0];
        car[i] = s9[8];
      end
    end else begin
      for (int h = 0; h < 2; h++) begin
        sb  = sub[h];
        s17 = {1'b0, a[16*h +: 16]} + {1'b0, (sb ? ~b[16*h +: 16] : b[16*h +: 16])} + {16'h0, sb};
        res[16*h +: 16] = s17[15:0];
        car[2*h+1] = s17[16];
      end
    end
    return {car, res};
  endfunction

  // Op timeline model: 0 idle, 1 low pass, 2 high pass, 3 result presented.
  int          m_phase = 0;
  logic [31:0] m_a, m_b, m_res;
  logic        m_w32, m_w8;
  logic [1:0]  m_sub;
  logic [3:0]  m_car;
  logic [31:0] m_perf = 0;

  always @(posedge clk_i) begin
    if (rst_i) begin
      m_phase = 0;
      m_perf  = 0;
    end else begin
      case (m_phase)
        0: if (start_i) begin
          m_a = operand_a_i; m_b = operand_b_i; m_w32 = width32_i;
          m_w8 = width8_i; m_sub = alu_sub_i; m_phase = 1;
        end
        1: m_phase = kill_i ? 0 : 2;
        2: if (kill_i) m_phase = 0;
           else begin
             {m_car, m_res} = ref_op(m_a, m_b, m_w32, m_w8, m_sub);
             m_phase = 3;
             if (m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 1;
           end
        default: if (kill_i || result_ack_i) m_phase = 0;
      endcase
    end
  end

  logic [15:0] e_a, e_b;
  logic        e_sub, e_bm;
  logic [1:0]  e_cin;
  logic [16:0] lo17;
  always @(negedge clk_i) begin
    if (check_en) begin
      e_a = 0; e_b = 0; e_sub = 0; e_cin = 0; e_bm = 0;
      if (m_phase == 1) begin
        e_a = m_a[15:0]; e_b = m_b[15:0]; e_sub = m_sub[0];
        e_bm = m_w8 & ~m_w32;
        e_cin = e_bm ? {2{m_sub[0]}} : {1'b0, m_sub[0]};
      end else if (m_phase == 2) begin
        e_a = m_a[31:16]; e_b = m_b[31:16];
        e_bm = m_w8 & ~m_w32;
        if (m_w32) begin
          lo17 = {1'b0, m_a[15:0]} + {1'b0, (m_sub[0] ? ~m_b[15:0] : m_b[15:0])} + {16'h0, m_sub[0]};
          e_sub = m_sub[0];
          e_cin = {1'b0, lo17[16]};
        end else begin
          e_sub = m_sub[1];
          e_cin = e_bm ? {2{m_sub[1]}} : {1'b0, m_sub[1]};
        end
      end
      chk("ready", ready_o, m_phase == 0);
      chk("valid", valid_o, m_phase == 3);
      chk("adder_a", adder_a_o, e_a);
      chk("adder_b", adder_b_o, e_b);
      chk("adder_sub", adder_sub_o, e_sub);
      chk("adder_cin", adder_cin_o, e_cin);
      chk("adder_byte_mode", adder_byte_mode_o, e_bm);
      if (m_phase == 3) begin
        chk("result", result_o, m_res);
        chk("carry", carry_o, m_car);
      end
`ifdef IBEX_PEXT_MC_PERF_CNT_EN
      chk("perf_ops", perf_ops_o, m_perf);
`endif
    end
  end

  logic [31:0] r_res;
  logic [3:0]  r_car;
  logic        r_lo_sub, r_hi_sub, r_bm, r_valid;
  logic [1:0]  r_lo_cin, r_hi_cin;

  // Issue one op and sample its LO, HI and DONE cycles at fixed latency.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic w32,
                        input logic w8, input logic [1:0] sub, input logic with_kill);
    @(posedge clk_i); #2;
    start_i = 1; kill_i = with_kill; operand_a_i = a; operand_b_i = b;
    width32_i = w32; width8_i = w8; alu_sub_i = sub;
    @(posedge clk_i); #2;
    start_i = 0; kill_i = 0;
    @(negedge clk_i);
    r_lo_sub = adder_sub_o; r_lo_cin = adder_cin_o; r_bm = adder_byte_mode_o;
    @(negedge clk_i);
    r_hi_sub = adder_sub_o; r_hi_cin = adder_cin_o;
    @(negedge clk_i);
    r_valid = valid_o; r_res = result_o; r_car = carry_o;
  endtask

  task automatic ack_op();
    @(posedge clk_i); #2 result_ack_i = 1;
    @(posedge clk_i); #2 result_ack_i = 0;
  endtask

  initial begin
    rst_i = 1; start_i = 0; kill_i = 0; width32_i = 0; width8_i = 0;
    alu_sub_i = 0; operand_a_i = 0; operand_b_i = 0; result_ack_i = 0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset ready", ready_o, 1'b1);
    chk("reset valid", valid_o, 1'b0);
    chk("reset result", result_o, 32'h0);
    chk("reset carry", carry_o, 4'h0);
    chk("reset adder_a", adder_a_o, 16'h0);
    @(posedge clk_i); #2 rst_i = 0; check_en = 1;

    run_op(32'h0001_FFFF, 32'h0000_0001, 1, 0, 2'b00, 0);
    chk("word add valid@N+3", r_valid, 1'b1);
    chk("word add result", r_res, 32'h0002_0000);
    chk("word add carry", r_car, 4'h0);
    chk("word add HI cin", r_hi_cin, 2'b01);
    ack_op();

    run_op(32'h0000_0000, 32'h0000_0001, 1, 0, 2'b11, 0);
    chk("word sub result", r_res, 32'hFFFF_FFFF);
    chk("word sub carry", r_car, 4'h0);
    chk("word sub LO cin", r_lo_cin, 2'b01);
    chk("word sub HI cin", r_hi_cin, 2'b00);
    ack_op();

    run_op(32'h0005_0003, 32'h0002_0001, 0, 0, 2'b01, 0);
    chk("half result", r_res, 32'h0007_0002);
    chk("half carry", r_car, 4'h2);
    chk("half LO sub", r_lo_sub, 1'b1);
    chk("half HI sub", r_hi_sub, 1'b0);
    ack_op();

    run_op(32'h1010_1010, 32'h0101_0101, 0, 1, 2'b11, 0);
    chk("byte mode", r_bm, 1'b1);
    chk("byte cin", r_lo_cin, 2'b11);
    chk("byte result", r_res, 32'h0F0F_0F0F);
    chk("byte carry", r_car, 4'hF);

    // Backpressure: result held, further start requests ignored.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #2;
      start_i = 1; operand_a_i = $urandom; operand_b_i = $urandom;
      @(negedge clk_i);
      chk("hold valid", valid_o, 1'b1);
      chk("hold result", result_o, 32'h0F0F_0F0F);
      chk("hold ready", ready_o, 1'b0);
    end
    @(posedge clk_i); #2 start_i = 0;
    ack_op();
    @(negedge clk_i);
    chk("ready after ack", ready_o, 1'b1);

    // Kill during the high pass.
    @(posedge clk_i); #2;
    start_i = 1; operand_a_i = 32'h1234_5678; operand_b_i = 32'h1111_1111;
    width32_i = 1; width8_i = 0; alu_sub_i = 2'b00;
    @(posedge clk_i); #2 start_i = 0;
    @(posedge clk_i); #2 kill_i = 1;
    @(posedge clk_i); #2 kill_i = 0;
    @(negedge clk_i);
    chk("kill ready", ready_o, 1'b1);
    chk("kill valid", valid_o, 1'b0);

    // Reset during the low pass.
    @(posedge clk_i); #2 start_i = 1;
    @(posedge clk_i); #2 start_i = 0; rst_i = 1;
    @(posedge clk_i); #2 rst_i = 0;
    @(negedge clk_i);
    chk("rst ready", ready_o, 1'b1);
    chk("rst valid", valid_o, 1'b0);
    chk("rst result", result_o, 32'h0);
    chk("rst carry", carry_o, 4'h0);
    chk("rst adder_b", adder_b_o, 16'h0);

    // Start coincident with kill in IDLE must still be accepted.
    run_op(32'h8000_0001, 32'h8000_0001, 1, 0, 2'b00, 1);
    chk("kill+start valid", r_valid, 1'b1);
    chk("kill+start result", r_res, 32'h0000_0002);
    chk("kill+start carry", r_car, 4'h8);
    ack_op();

    for (int c = 0; c < 600; c++) begin
      @(posedge clk_i); #2;
      start_i      = ($urandom_range(0, 2) == 0);
      kill_i       = ($urandom_range(0, 11) == 0);
      result_ack_i = $urandom_range(0, 1);
      rst_i        = ($urandom_range(0, 96) == 0);
      width32_i    = ($urandom_range(0, 2) == 0);
      width8_i     = $urandom_range(0, 1);
      alu_sub_i    = 2'($urandom_range(0, 3));
      operand_a_i  = $urandom;
      operand_b_i  = $urandom;
    end
    @(posedge clk_i); #2;
    start_i = 0; kill_i = 0; rst_i = 0; result_ack_i = 1;
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    check_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
